// File: rtl/mux_sel_seq.sv
// mux_sel_seq -- parallel-in / serial-out sequencer for a downstream mux_nx1.
//
// A start in IDLE latches seq_load_data into seq_word (mux data inputs) and
// steps seq_sel (mux select) across every input, holding each value for
// TICK_DIV clocks. seq_bit_strobe marks the last clock of each bit period,
// when the mux output has settled. seq_done pulses once after the last bit.
//
// Ports:
//   clk            in   rising-edge system clock
//   rst            in   synchronous active-high reset
//   seq_start      in   load-and-scan request, honoured only in IDLE
//   seq_load_data  in   SIZE-bit word captured on an accepted start
//   seq_word       out  registered word, drives mux_nx1_in
//   seq_sel        out  registered select, drives mux_nx1_sel
//   seq_busy       out  high while scanning
//   seq_bit_strobe out  one-cycle pulse at the end of each bit period
//   seq_done       out  one-cycle pulse after the final bit period
module mux_sel_seq #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned TICK_DIV  = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    seq_start,
  input  logic [SIZE-1:0]         seq_load_data,
  output logic [SIZE-1:0]         seq_word,
  output logic [$clog2(SIZE)-1:0] seq_sel,
  output logic                    seq_busy,
  output logic                    seq_bit_strobe,
  output logic                    seq_done
);

  localparam int unsigned SEL_W = $clog2(SIZE);

  // Select end points depend on scan direction; the terminal value is the
  // last legal input, so sel never enters codes >= SIZE.
  localparam logic [SEL_W-1:0] SEL_TOP   = SEL_W'(SIZE - 32'd1);
  localparam logic [SEL_W-1:0] SEL_ZERO  = SEL_W'(32'd0);
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(32'd1);
  localparam logic [SEL_W-1:0] SEL_FIRST = MSB_FIRST ? SEL_TOP : SEL_ZERO;
  localparam logic [SEL_W-1:0] SEL_LAST  = MSB_FIRST ? SEL_ZERO : SEL_TOP;

  // TICK_DIV tops out at 255, so an 8-bit divider covers every legal value
  // (including TICK_DIV=1, where the divider stays at 0).
  localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SIZE-1:0]   word_q,  word_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;
  logic [7:0]        div_q,   div_d;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      sel_q   <= '0;
      div_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
      div_q   <= div_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    sel_d   = sel_q;
    div_d   = div_q;
    case (state_q)
      ST_IDLE: begin
        if (seq_start) begin
          word_d  = seq_load_data;
          sel_d   = SEL_FIRST;
          div_d   = 8'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (div_q == DIV_LAST) begin
          div_d = 8'd0;
          if (sel_q == SEL_LAST) begin
            // Leave sel on the terminal input rather than stepping past it.
            state_d = ST_DONE;
          end else if (MSB_FIRST) begin
            sel_d = sel_q - SEL_ONE;
          end else begin
            sel_d = sel_q + SEL_ONE;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_DONE: begin
        // Starts seen here are dropped; the next one is taken in IDLE.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered state and divider.
  always_comb begin
    seq_busy       = 1'b0;
    seq_bit_strobe = 1'b0;
    seq_done       = 1'b0;
    case (state_q)
      ST_RUN: begin
        seq_busy       = 1'b1;
        seq_bit_strobe = (div_q == DIV_LAST);
      end
      ST_DONE: begin
        seq_done = 1'b1;
      end
      default: begin
        seq_busy = 1'b0;
      end
    endcase
  end

  assign seq_word = word_q;
  assign seq_sel  = sel_q;

endmodule
